// File: rtl/unified_mem_arbiter_pkg.sv
// rtl/unified_mem_arbiter_pkg.sv - shared types and constants for the unified memory arbiter
package unified_mem_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } arb_state_t;

    localparam logic [2:0] FUNC3_WORD = 3'b010;

endpackage

// File: rtl/unified_mem_arbiter_watchdog_counter.sv
// rtl/unified_mem_arbiter_watchdog_counter.sv - saturating wait-cycle counter that flags an unacknowledged access
module watchdog_counter #(
    parameter int TIMEOUT_CYC = 16
) (
    input  logic clk,
    input  logic resetn,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT_CYC);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

    logic [CNT_W-1:0] r_count;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_count <= '0;
        end else if (clr) begin
            r_count <= '0;
        end else if (en && (r_count != CNT_MAX)) begin
            r_count <= r_count + 1'b1;
        end
    end

    // Fires on the wait cycle whose increment would reach the limit, so the
    // access sees exactly TIMEOUT_CYC wait cycles before being ended.
    assign expired = en && (r_count == CNT_LAST);

endmodule

// File: rtl/unified_mem_arbiter.sv
// rtl/unified_mem_arbiter.sv - shares one variable-latency memory between the fetch and data ports
module unified_mem_arbiter
    import unified_mem_arbiter_pkg::*;
#(
    parameter int ADDR_W      = 9,
    parameter int DATA_W      = 32,
    parameter int TIMEOUT_CYC = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_ready,
    input  logic              d_rd,
    input  logic              d_wr,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    input  logic [2:0]        d_func3,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_ready,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic [2:0]        mem_func3,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_valid,
    output logic              grant_d,
    output logic              err
);

    arb_state_t        r_state;
    logic              r_mem_en;
    logic              r_mem_we;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [DATA_W-1:0] r_mem_wdata;
    logic [2:0]        r_mem_func3;
    logic              r_if_ready;
    logic              r_d_ready;
    logic [DATA_W-1:0] r_if_rdata;
    logic [DATA_W-1:0] r_d_rdata;
    logic              r_grant_d;
    logic              r_err;

    logic w_wd_en;
    logic w_wd_clr;
    logic w_expired;

    assign w_wd_en  = (r_state == WAIT) && !mem_valid;
    assign w_wd_clr = (r_state != WAIT) || mem_valid;

    watchdog_counter #(
        .TIMEOUT_CYC(TIMEOUT_CYC)
    ) u_watchdog (
        .clk    (clk),
        .resetn (reset),
        .clr    (w_wd_clr),
        .en     (w_wd_en),
        .expired(w_expired)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state     <= IDLE;
            r_mem_en    <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_mem_func3 <= '0;
            r_if_ready  <= 1'b0;
            r_d_ready   <= 1'b0;
            r_if_rdata  <= '0;
            r_d_rdata   <= '0;
            r_grant_d   <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_mem_en   <= 1'b0;
            r_if_ready <= 1'b0;
            r_d_ready  <= 1'b0;
            case (r_state)
                // Data wins a tie: the older instruction in MEM must retire first.
                IDLE: begin
                    if (d_rd || d_wr) begin
                        r_mem_addr  <= d_addr;
                        r_mem_wdata <= d_wdata;
                        r_mem_func3 <= d_func3;
                        r_mem_we    <= d_wr;
                        r_grant_d   <= 1'b1;
                        r_mem_en    <= 1'b1;
                        r_state     <= ISSUE;
                    end else if (if_req) begin
                        r_mem_addr  <= if_addr;
                        r_mem_func3 <= FUNC3_WORD;
                        r_mem_we    <= 1'b0;
                        r_grant_d   <= 1'b0;
                        r_mem_en    <= 1'b1;
                        r_state     <= ISSUE;
                    end
                end
                ISSUE: begin
                    r_state <= WAIT;
                end
                WAIT: begin
                    if (mem_valid) begin
                        if (r_grant_d) begin
                            r_d_rdata <= r_mem_we ? '0 : mem_rdata;
                            r_d_ready <= 1'b1;
                        end else begin
                            r_if_rdata <= mem_rdata;
                            r_if_ready <= 1'b1;
                        end
                        r_state <= RESP;
                    end else if (w_expired) begin
                        if (r_grant_d) begin
                            r_d_rdata <= '0;
                            r_d_ready <= 1'b1;
                        end else begin
                            r_if_rdata <= '0;
                            r_if_ready <= 1'b1;
                        end
                        r_err   <= 1'b1;
                        r_state <= RESP;
                    end
                end
                RESP: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign if_rdata  = r_if_rdata;
    assign if_ready  = r_if_ready;
    assign d_rdata   = r_d_rdata;
    assign d_ready   = r_d_ready;
    assign mem_en    = r_mem_en;
    assign mem_we    = r_mem_we;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;
    assign mem_func3 = r_mem_func3;
    assign grant_d   = r_grant_d;
    assign err       = r_err;

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// tb/tb_unified_mem_arbiter.sv - directed self-checking bench for unified_mem_arbiter
module tb_unified_mem_arbiter;

    logic        clk;
    logic        reset;
    logic        if_req;
    logic [8:0]  if_addr;
    logic [31:0] if_rdata;
    logic        if_ready;
    logic        d_rd;
    logic        d_wr;
    logic [8:0]  d_addr;
    logic [31:0] d_wdata;
    logic [2:0]  d_func3;
    logic [31:0] d_rdata;
    logic        d_ready;
    logic        mem_en;
    logic        mem_we;
    logic [8:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic [2:0]  mem_func3;
    logic [31:0] mem_rdata;
    logic        mem_valid;
    logic        grant_d;
    logic        err;

    int checks;
    int errors;

    unified_mem_arbiter #(
        .ADDR_W     (9),
        .DATA_W     (32),
        .TIMEOUT_CYC(4)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .if_req   (if_req),
        .if_addr  (if_addr),
        .if_rdata (if_rdata),
        .if_ready (if_ready),
        .d_rd     (d_rd),
        .d_wr     (d_wr),
        .d_addr   (d_addr),
        .d_wdata  (d_wdata),
        .d_func3  (d_func3),
        .d_rdata  (d_rdata),
        .d_ready  (d_ready),
        .mem_en   (mem_en),
        .mem_we   (mem_we),
        .mem_addr (mem_addr),
        .mem_wdata(mem_wdata),
        .mem_func3(mem_func3),
        .mem_rdata(mem_rdata),
        .mem_valid(mem_valid),
        .grant_d  (grant_d),
        .err      (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: simulation time limit reached");
        $fatal(1, "time limit");
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        reset     = 1'b0;
        if_req    = 1'b0;
        if_addr   = '0;
        d_rd      = 1'b0;
        d_wr      = 1'b0;
        d_addr    = '0;
        d_wdata   = '0;
        d_func3   = '0;
        mem_rdata = '0;
        mem_valid = 1'b0;
        tick();
        tick();
        check("rst_mem_en", 32'(mem_en), 32'd0);
        check("rst_if_ready", 32'(if_ready), 32'd0);
        check("rst_d_ready", 32'(d_ready), 32'd0);
        check("rst_grant_d", 32'(grant_d), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_mem_addr", 32'(mem_addr), 32'd0);
        reset = 1'b1;
        tick();

        // Fetch, 1-cycle memory (cycle 0 = IDLE sampling the request)
        if_req  = 1'b1;
        if_addr = 9'h010;
        tick();
        check("f1_mem_en", 32'(mem_en), 32'd1);
        check("f1_mem_addr", 32'(mem_addr), 32'h010);
        check("f1_mem_func3", 32'(mem_func3), 32'h2);
        check("f1_mem_we", 32'(mem_we), 32'd0);
        tick();
        check("f1_mem_en_wait", 32'(mem_en), 32'd0);
        mem_valid = 1'b1;
        mem_rdata = 32'h00500093;
        tick();
        mem_valid = 1'b0;
        check("f1_if_ready", 32'(if_ready), 32'd1);
        check("f1_if_rdata", if_rdata, 32'h00500093);
        check("f1_d_ready", 32'(d_ready), 32'd0);
        if_req = 1'b0;
        tick();
        check("f1_if_ready_off", 32'(if_ready), 32'd0);
        check("f1_rdata_hold", if_rdata, 32'h00500093);

        // Simultaneous fetch and data read: data first
        if_req  = 1'b1;
        if_addr = 9'h040;
        d_rd    = 1'b1;
        d_addr  = 9'h040;
        d_func3 = 3'b010;
        tick();
        check("sim_mem_en_d", 32'(mem_en), 32'd1);
        check("sim_grant_d", 32'(grant_d), 32'd1);
        tick();
        mem_valid = 1'b1;
        mem_rdata = 32'hDEADBEEF;
        tick();
        mem_valid = 1'b0;
        check("sim_d_ready", 32'(d_ready), 32'd1);
        check("sim_d_rdata", d_rdata, 32'hDEADBEEF);
        check("sim_if_ready_c3", 32'(if_ready), 32'd0);
        d_rd = 1'b0;
        tick();
        check("sim_mem_en_c4", 32'(mem_en), 32'd0);
        tick();
        check("sim_mem_en_f", 32'(mem_en), 32'd1);
        check("sim_grant_f", 32'(grant_d), 32'd0);
        check("sim_func3_f", 32'(mem_func3), 32'h2);
        tick();
        mem_valid = 1'b1;
        mem_rdata = 32'h00A00113;
        tick();
        mem_valid = 1'b0;
        check("sim_if_ready", 32'(if_ready), 32'd1);
        check("sim_if_rdata", if_rdata, 32'h00A00113);
        if_req = 1'b0;
        tick();

        // Store, 3-cycle memory
        d_wr    = 1'b1;
        d_addr  = 9'h020;
        d_wdata = 32'h12345678;
        d_func3 = 3'b000;
        tick();
        check("st_mem_en", 32'(mem_en), 32'd1);
        check("st_mem_we", 32'(mem_we), 32'd1);
        check("st_mem_addr", 32'(mem_addr), 32'h020);
        check("st_mem_wdata", mem_wdata, 32'h12345678);
        check("st_mem_func3", 32'(mem_func3), 32'd0);
        tick();
        tick();
        check("st_d_ready_early", 32'(d_ready), 32'd0);
        tick();
        mem_valid = 1'b1;
        mem_rdata = 32'hFFFFFFFF;
        tick();
        mem_valid = 1'b0;
        check("st_d_ready", 32'(d_ready), 32'd1);
        check("st_d_rdata", d_rdata, 32'd0);
        check("st_wdata_stable", mem_wdata, 32'h12345678);
        d_wr = 1'b0;
        tick();

        // Timeout: memory never acknowledges, TIMEOUT_CYC=4
        if_req  = 1'b1;
        if_addr = 9'h030;
        tick();
        check("to_mem_en", 32'(mem_en), 32'd1);
        tick();
        tick();
        tick();
        tick();
        check("to_if_ready_c5", 32'(if_ready), 32'd0);
        check("to_err_c5", 32'(err), 32'd0);
        tick();
        check("to_if_ready", 32'(if_ready), 32'd1);
        check("to_if_rdata", if_rdata, 32'd0);
        check("to_err", 32'(err), 32'd1);
        if_addr = 9'h034;
        tick();
        tick();
        tick();
        mem_valid = 1'b1;
        mem_rdata = 32'h00000013;
        tick();
        mem_valid = 1'b0;
        check("to2_if_ready", 32'(if_ready), 32'd1);
        check("to2_if_rdata", if_rdata, 32'h00000013);
        check("to2_err_sticky", 32'(err), 32'd1);
        if_req = 1'b0;
        tick();

        // Reset mid-WAIT during a data read
        d_rd    = 1'b1;
        d_addr  = 9'h044;
        d_func3 = 3'b010;
        tick();
        tick();
        reset = 1'b0;
        tick();
        reset     = 1'b1;
        d_rd      = 1'b0;
        check("rw_err", 32'(err), 32'd0);
        check("rw_grant_d", 32'(grant_d), 32'd0);
        check("rw_d_rdata", d_rdata, 32'd0);
        check("rw_if_rdata", if_rdata, 32'd0);
        check("rw_mem_addr", 32'(mem_addr), 32'd0);
        mem_valid = 1'b1;
        mem_rdata = 32'hCAFEF00D;
        tick();
        mem_valid = 1'b0;
        check("rw_d_ready", 32'(d_ready), 32'd0);
        check("rw_mem_en", 32'(mem_en), 32'd0);
        check("rw_err_after", 32'(err), 32'd0);
        tick();

        // Stray acknowledge in IDLE and ISSUE
        mem_valid = 1'b1;
        mem_rdata = 32'h11111111;
        tick();
        check("sa_idle_ready", 32'(if_ready), 32'd0);
        if_req  = 1'b1;
        if_addr = 9'h050;
        tick();
        check("sa_mem_en", 32'(mem_en), 32'd1);
        tick();
        mem_valid = 1'b0;
        check("sa_issue_ready", 32'(if_ready), 32'd0);
        tick();
        mem_valid = 1'b1;
        mem_rdata = 32'h13579BDF;
        tick();
        mem_valid = 1'b0;
        check("sa_if_ready", 32'(if_ready), 32'd1);
        check("sa_if_rdata", if_rdata, 32'h13579BDF);
        check("sa_err", 32'(err), 32'd0);
        if_req = 1'b0;
        tick();
        check("sa_idle_after", 32'(if_ready), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/unified_mem_arbiter.md
Name: unified_mem_arbiter

Overview:
- Shares one single-port, variable-latency memory between the instruction-fetch port (IF stage) and the data port (MEM stage) of the 5-stage RISC-V pipeline.
- Sequences each access: issue, wait for the memory acknowledge, return the response. Each requester sees a one-cycle ready pulse.
- The pipeline stalls IF or MEM while its request is pending.
- A watchdog ends any access that the memory never acknowledges and flags the error.

Parameters:
- ADDR_W, 9, byte address width (same as PC_W and DM_ADDRESS).
- DATA_W, 32, data width.
- TIMEOUT_CYC, 16, maximum WAIT cycles before the watchdog ends the access (≥1).

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- reset  in  1  synchronous, active-low reset: reset=0 at a rising edge resets the block.
- if_req  in  1  instruction fetch request; held stable until if_ready.
- if_addr  in  ADDR_W  fetch address.
- if_rdata  out  DATA_W  fetched instruction; valid while if_ready=1.
- if_ready  out  1  one-cycle completion pulse for the fetch.
- d_rd  in  1  data read request; held until d_ready.
- d_wr  in  1  data write request; held until d_ready. d_rd and d_wr are never both 1.
- d_addr  in  ADDR_W  data address.
- d_wdata  in  DATA_W  store data.
- d_func3  in  3  load/store size code, passed through to memory.
- d_rdata  out  DATA_W  load data; valid while d_ready=1.
- d_ready  out  1  one-cycle completion pulse for the data access.
- mem_en  out  1  one-cycle access strobe.
- mem_we  out  1  write qualifier; valid with mem_en.
- mem_addr  out  ADDR_W  latched address.
- mem_wdata  out  DATA_W  latched store data.
- mem_func3  out  3  latched func3. Fetches use 3'b010 (word).
- mem_rdata  in  DATA_W  memory read data; valid with mem_valid.
- mem_valid  in  1  memory acknowledge for reads and writes.
- grant_d  out  1  1 while the current or last transaction belongs to the data port.
- err  out  1  sticky timeout flag.

Behaviour:
- Reset (reset=0 at an edge):
  - state=IDLE.
  - All outputs 0: mem_en, mem_we, mem_addr, mem_wdata, mem_func3, if_ready, d_ready, if_rdata, d_rdata, grant_d, err.
  - Watchdog counter = 0.
  - Reset mid-transaction abandons the access with no ready pulse.
- FSM states:
  - IDLE:
    - d_rd or d_wr pending → latch d_addr/d_wdata/d_func3, mem_we=d_wr, grant_d=1, go to ISSUE.
    - Otherwise if_req → latch if_addr, func3=010, mem_we=0, grant_d=0, go to ISSUE.
    - Data always wins a simultaneous request, because the older instruction must complete. The fetch is granted on the next IDLE visit.
  - ISSUE (1 cycle): mem_en=1; go to WAIT. mem_valid is ignored in ISSUE, so memory latency must be ≥1.
  - WAIT:
    - mem_valid=1 → capture mem_rdata into the granted port's rdata register (or 0 for a write), clear the counter, go to RESP.
    - Else counter increments. When the counter reaches TIMEOUT_CYC → rdata register=0, err=1, go to RESP.
  - RESP (1 cycle): if_ready or d_ready=1 according to grant_d; go to IDLE unconditionally.
- Latency: minimum 4 cycles from the request being sampled in IDLE to the ready pulse, for a 1-cycle memory: IDLE→ISSUE→WAIT→RESP.
- Back-to-back: next grant decision at the IDLE cycle after RESP.
- Requester rule: the requester drops or changes its request at the edge that ends its RESP cycle.
- rdata registers hold their value until the next capture.
- mem_addr, mem_wdata and mem_func3 stay stable from ISSUE through RESP.
- mem_valid in IDLE, ISSUE or RESP is ignored and raises no error.
- err clears only on reset.
- Counter width: $clog2(TIMEOUT_CYC+1). It never wraps, because it saturates at TIMEOUT_CYC.

Decomposition:
- Shared package: arb_state_t enum {IDLE, ISSUE, WAIT, RESP}, and constant FUNC3_WORD=3'b010.
- One sub-module: watchdog_counter. Inputs: clr, en. Output: expired. Parameter: TIMEOUT_CYC.

Test Plan:
- Fetch, 1-cycle memory:
  - Stimulus: if_req=1, if_addr=9'h010; memory returns 32'h00500093.
  - Response: mem_en at cycle 1 with mem_addr=010 and mem_func3=010; if_ready=1 with if_rdata=00500093 at cycle 3.
- Simultaneous requests in IDLE:
  - Stimulus: if_req and d_rd at addr 9'h040, memory returns 32'hDEADBEEF.
  - Response: data transaction first; d_ready with d_rdata=DEADBEEF at cycle 3; fetch mem_en at cycle 5; if_ready at cycle 7.
- Store, 3-cycle memory:
  - Stimulus: d_wr, d_addr=9'h020, d_wdata=32'h12345678, d_func3=000.
  - Response: mem_we=1 with the latched values; d_ready at cycle 5; d_rdata=0.
- Timeout, TIMEOUT_CYC=4:
  - Stimulus: memory never asserts mem_valid.
  - Response: if_ready with if_rdata=0 exactly 4 WAIT cycles after ISSUE; err=1 and stays 1 through a later successful fetch.
- Reset mid-WAIT:
  - Stimulus: reset=0 for one edge during a data read, then mem_valid arrives.
  - Response: no d_ready; all outputs 0; the stray mem_valid in IDLE is ignored.
- Stray acknowledge:
  - Stimulus: mem_valid pulsed in IDLE and in ISSUE.
  - Response: no ready pulse, err=0, the transaction completes normally on the real acknowledge.
